// File: rtl/calc_seq_ctrl.sv
// Two-digit PS/2 calculator sequencer: scancode decode, operand entry,
// shared-ALU request handshake with timeout, and BCD result formatting.
`timescale 1ns/1ps
module calc_seq_ctrl #(
   parameter int ACK_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] key_code,
   input  logic       key_valid,
   output logic       alu_req,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic       alu_op,
   input  logic       alu_ack,
   input  logic [7:0] alu_result,
   output logic [3:0] n1,
   output logic [3:0] n2,
   output logic       n1_vld,
   output logic       n2_vld,
   output logic [1:0] op_code,
   output logic       eq_vld,
   output logic       res_vld,
   output logic       res_neg,
   output logic [3:0] res_tens,
   output logic [3:0] res_ones,
   output logic       err
);

   typedef enum logic [2:0] {
      S_N1, S_OP, S_N2, S_EQ, S_REQ, S_SHOW, S_ERR
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

   state_t           state;
   logic             brk;
   logic [CNT_W-1:0] cnt;

   logic       dig_hit;
   logic [3:0] dig_val;
   logic       kv, k_dig, k_plus, k_minus, k_eq, k_esc;

   always_comb begin
      dig_hit = 1'b1;
      dig_val = 4'd0;
      case (key_code)
         8'h45:   dig_val = 4'd0;
         8'h16:   dig_val = 4'd1;
         8'h1E:   dig_val = 4'd2;
         8'h26:   dig_val = 4'd3;
         8'h25:   dig_val = 4'd4;
         8'h2E:   dig_val = 4'd5;
         8'h36:   dig_val = 4'd6;
         8'h3D:   dig_val = 4'd7;
         8'h3E:   dig_val = 4'd8;
         8'h46:   dig_val = 4'd9;
         default: dig_hit = 1'b0;
      endcase
   end

   // Prefix bytes and the byte after a break code never reach the FSM.
   assign kv = key_valid && !brk
            && key_code != 8'hF0
            && key_code != 8'hE0;
   assign k_dig   = kv && dig_hit;
   assign k_plus  = kv && key_code == 8'h79;
   assign k_minus = kv && key_code == 8'h7B;
   assign k_eq    = kv && key_code == 8'h55;
   assign k_esc   = kv && key_code == 8'h76;

   logic signed [7:0] r_s;
   logic        [7:0] mag;
   logic              in_rng;
   logic              big;

   assign r_s    = alu_result;
   assign mag    = r_s[7] ? (~alu_result + 8'd1) : alu_result;
   assign in_rng = (r_s >= -8'sd9) && (r_s <= 8'sd18);
   assign big    = mag >= 8'd10;

   assign alu_a  = n1;
   assign alu_b  = n2;
   assign alu_op = op_code[1];

   always_ff @(posedge clk) begin
      if (!reset || k_esc) begin
         state    <= S_N1;
         cnt      <= '0;
         alu_req  <= 1'b0;
         n1       <= 4'd0;
         n2       <= 4'd0;
         n1_vld   <= 1'b0;
         n2_vld   <= 1'b0;
         op_code  <= 2'b00;
         eq_vld   <= 1'b0;
         res_vld  <= 1'b0;
         res_neg  <= 1'b0;
         res_tens <= 4'd0;
         res_ones <= 4'd0;
         err      <= 1'b0;
      end else begin
         case (state)
            S_N1: if (k_dig) begin
               n1     <= dig_val;
               n1_vld <= 1'b1;
               state  <= S_OP;
            end
            S_OP: begin
               if (k_dig) n1 <= dig_val;
               else if (k_plus) begin
                  op_code <= 2'b01;
                  state   <= S_N2;
               end else if (k_minus) begin
                  op_code <= 2'b10;
                  state   <= S_N2;
               end
            end
            S_N2: if (k_dig) begin
               n2     <= dig_val;
               n2_vld <= 1'b1;
               state  <= S_EQ;
            end
            S_EQ: begin
               if (k_dig) n2 <= dig_val;
               else if (k_eq) begin
                  eq_vld  <= 1'b1;
                  alu_req <= 1'b1;
                  cnt     <= '0;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (alu_ack) begin
                  alu_req <= 1'b0;
                  if (in_rng) begin
                     res_vld  <= 1'b1;
                     res_neg  <= r_s[7];
                     res_tens <= {3'b000, big};
                     res_ones <= big ? 4'(mag - 8'd10)
                                     : 4'(mag);
                     state    <= S_SHOW;
                  end else begin
                     err   <= 1'b1;
                     state <= S_ERR;
                  end
               end else if (cnt == TO_LAST) begin
                  alu_req <= 1'b0;
                  err     <= 1'b1;
                  state   <= S_ERR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SHOW: if (k_dig) begin
               n1       <= dig_val;
               n1_vld   <= 1'b1;
               n2       <= 4'd0;
               n2_vld   <= 1'b0;
               op_code  <= 2'b00;
               eq_vld   <= 1'b0;
               res_vld  <= 1'b0;
               res_neg  <= 1'b0;
               res_tens <= 4'd0;
               res_ones <= 4'd0;
               state    <= S_OP;
            end
            S_ERR: ;
            default: state <= S_N1;
         endcase
      end
      if (!reset) brk <= 1'b0;
      else if (key_valid) brk <= !brk && key_code == 8'hF0;
   end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: entry, break/prefix bytes, ALU
// handshake, timeout, range error, Esc priority and reset abort.
`timescale 1ns/1ps
module tb_calc_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] key_code;
   logic       key_valid;
   logic       alu_req;
   logic [3:0] alu_a, alu_b;
   logic       alu_op;
   logic       alu_ack;
   logic [7:0] alu_result;
   logic [3:0] n1, n2;
   logic       n1_vld, n2_vld;
   logic [1:0] op_code;
   logic       eq_vld, res_vld, res_neg;
   logic [3:0] res_tens, res_ones;
   logic       err;

   int errors = 0;
   int checks = 0;

   wire [33:0] outs = {alu_req, alu_a, alu_b, alu_op, n1, n2,
                       n1_vld, n2_vld, op_code, eq_vld, res_vld,
                       res_neg, res_tens, res_ones, err};

   always #5 clk = ~clk;

   calc_seq_ctrl #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .key_code(key_code), .key_valid(key_valid),
      .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_ack(alu_ack), .alu_result(alu_result),
      .n1(n1), .n2(n2), .n1_vld(n1_vld), .n2_vld(n2_vld),
      .op_code(op_code), .eq_vld(eq_vld), .res_vld(res_vld),
      .res_neg(res_neg), .res_tens(res_tens), .res_ones(res_ones),
      .err(err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1 key_code = b;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic enter_1p1();
      send(8'h76);
      send(8'h16);
      send(8'h79);
      send(8'h16);
      send(8'h55);
   endtask

   // ack is sampled on the lat-th edge after alu_req rose
   task automatic do_ack(input int lat, input logic [7:0] res,
                         output int hi);
      hi = alu_req ? 1 : 0;
      repeat (lat - 1) begin
         tick();
         if (alu_req) hi++;
      end
      alu_ack = 1'b1;
      alu_result = res;
      tick();
      alu_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      key_valid = 1'b0;
      key_code = 8'h00;
      alu_ack = 1'b0;
      alu_result = 8'h00;
      tick();
      tick();
      checks++;
      if (outs !== 34'd0) begin
         errors++;
         $display("FAIL reset_outs got=%h exp=0", outs);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_illegal();
      send(8'h79);
      send(8'h55);
      checks++;
      if (outs !== 34'd0) begin
         errors++;
         $display("FAIL illegal_keys got=%h exp=0", outs);
      end
   endtask

   task automatic test_add();
      int hi;
      send(8'h16);
      send(8'h79);
      send(8'h16);
      send(8'h55);
      checks++;
      if ({alu_req, eq_vld, n1, op_code, n2, alu_a, alu_b, alu_op}
          !== {1'b1, 1'b1, 4'd1, 2'b01, 4'd1, 4'd1, 4'd1, 1'b0}) begin
         errors++;
         $display("FAIL add_entry req=%b eq=%b n1=%0d op=%b n2=%0d",
                  alu_req, eq_vld, n1, op_code, n2);
      end
      do_ack(3, 8'h02, hi);
      checks++;
      if (hi !== 3) begin
         errors++;
         $display("FAIL add_req_len got=%0d exp=3", hi);
      end
      checks++;
      if ({alu_req, res_vld, res_neg, res_tens, res_ones, err}
          !== {1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0}) begin
         errors++;
         $display("FAIL add_result req=%b vld=%b neg=%b t=%0d o=%0d",
                  alu_req, res_vld, res_neg, res_tens, res_ones);
      end
   endtask

   task automatic test_sub_break();
      int hi;
      send(8'h76);
      send(8'h2E);
      send(8'hF0);
      send(8'h2E);
      send(8'hF0);
      send(8'h16);
      checks++;
      if (n1 !== 4'd5) begin
         errors++;
         $display("FAIL break_discard n1 got=%0d exp=5", n1);
      end
      send(8'hE0);
      send(8'h7B);
      checks++;
      if (op_code !== 2'b10) begin
         errors++;
         $display("FAIL e0_prefix op got=%b exp=10", op_code);
      end
      send(8'h3E);
      send(8'h55);
      checks++;
      if ({n1, n2, alu_op, alu_req} !== {4'd5, 4'd8, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL sub_entry n1=%0d n2=%0d op=%b req=%b",
                  n1, n2, alu_op, alu_req);
      end
      do_ack(1, 8'hFD, hi);
      checks++;
      if ({res_vld, res_neg, res_tens, res_ones}
          !== {1'b1, 1'b1, 4'd0, 4'd3}) begin
         errors++;
         $display("FAIL sub_result vld=%b neg=%b t=%0d o=%0d",
                  res_vld, res_neg, res_tens, res_ones);
      end
   endtask

   task automatic test_nine_restart();
      int hi;
      send(8'h76);
      send(8'h46);
      send(8'h79);
      send(8'h46);
      send(8'h55);
      do_ack(2, 8'h12, hi);
      checks++;
      if ({res_vld, res_neg, res_tens, res_ones}
          !== {1'b1, 1'b0, 4'd1, 4'd8}) begin
         errors++;
         $display("FAIL nine_result vld=%b neg=%b t=%0d o=%0d",
                  res_vld, res_neg, res_tens, res_ones);
      end
      send(8'h26);
      checks++;
      if ({n1, n1_vld, n2, n2_vld, op_code, eq_vld, res_vld,
           res_tens, res_ones}
          !== {4'd3, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0,
               4'd0, 4'd0}) begin
         errors++;
         $display("FAIL restart outs=%h", outs);
      end
      send(8'h79);
      checks++;
      if (op_code !== 2'b01) begin
         errors++;
         $display("FAIL restart_in_op op got=%b exp=01", op_code);
      end
   endtask

   task automatic test_timeout();
      int hi = 0;
      enter_1p1();
      for (int i = 0; i < 10; i++) begin
         if (!alu_req) break;
         hi++;
         tick();
      end
      checks++;
      if (hi !== 4) begin
         errors++;
         $display("FAIL timeout_len got=%0d exp=4", hi);
      end
      checks++;
      if ({alu_req, err, res_vld} !== 3'b010) begin
         errors++;
         $display("FAIL timeout_err req=%b err=%b vld=%b",
                  alu_req, err, res_vld);
      end
      alu_ack = 1'b1;
      alu_result = 8'h02;
      tick();
      alu_ack = 1'b0;
      send(8'h26);
      checks++;
      if ({res_vld, err, n1, alu_req} !== {1'b0, 1'b1, 4'd1, 1'b0}) begin
         errors++;
         $display("FAIL err_hold vld=%b err=%b n1=%0d req=%b",
                  res_vld, err, n1, alu_req);
      end
      send(8'h76);
      checks++;
      if (outs !== 34'd0) begin
         errors++;
         $display("FAIL err_esc got=%h exp=0", outs);
      end
   endtask

   task automatic test_range();
      int hi;
      enter_1p1();
      do_ack(1, 8'h13, hi);
      checks++;
      if ({alu_req, err, res_vld} !== 3'b010) begin
         errors++;
         $display("FAIL range_hi req=%b err=%b vld=%b",
                  alu_req, err, res_vld);
      end
      enter_1p1();
      do_ack(1, 8'hF7, hi);
      checks++;
      if ({err, res_vld, res_neg, res_ones} !== {1'b0, 1'b1, 1'b1, 4'd9}) begin
         errors++;
         $display("FAIL range_lo err=%b vld=%b neg=%b o=%0d",
                  err, res_vld, res_neg, res_ones);
      end
      enter_1p1();
      do_ack(1, 8'hF6, hi);
      checks++;
      if ({err, res_vld} !== 2'b10) begin
         errors++;
         $display("FAIL range_neg10 err=%b vld=%b", err, res_vld);
      end
   endtask

   task automatic test_esc_ack();
      enter_1p1();
      key_code = 8'h76;
      key_valid = 1'b1;
      alu_ack = 1'b1;
      alu_result = 8'h02;
      tick();
      key_valid = 1'b0;
      alu_ack = 1'b0;
      tick();
      checks++;
      if (outs !== 34'd0) begin
         errors++;
         $display("FAIL esc_vs_ack got=%h exp=0", outs);
      end
      send(8'h16);
      checks++;
      if ({n1, n1_vld, op_code} !== {4'd1, 1'b1, 2'b00}) begin
         errors++;
         $display("FAIL esc_to_n1 n1=%0d vld=%b", n1, n1_vld);
      end
   endtask

   task automatic test_reset_abort();
      enter_1p1();
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (alu_req !== 1'b0 || outs !== 34'd0) begin
         errors++;
         $display("FAIL reset_abort got=%h exp=0", outs);
      end
      reset = 1'b1;
      alu_ack = 1'b1;
      alu_result = 8'h02;
      tick();
      alu_ack = 1'b0;
      tick();
      checks++;
      if (outs !== 34'd0) begin
         errors++;
         $display("FAIL stale_ack got=%h exp=0", outs);
      end
   endtask

   initial begin
      test_reset();
      test_illegal();
      test_add();
      test_sub_break();
      test_nine_restart();
      test_timeout();
      test_range();
      test_esc_ack();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: max cycles alu_req may wait for alu_ack.
REQ-002 SHALL have parameter CNT_W, default 8: width of the timeout counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; state clears on rising clk edge while reset=0.
REQ-005 SHALL have port key_code  input  8  received PS/2 scancode byte.
REQ-006 SHALL have port key_valid  input  1  one-cycle strobe, key_code valid.
REQ-007 SHALL have port alu_req  output  1  compute request to shared ALU.
REQ-008 SHALL have ports alu_a, alu_b  output  4 each  operands, binary 0-9.
REQ-009 SHALL have port alu_op  output  1  0=add, 1=subtract.
REQ-010 SHALL have port alu_ack  input  1  ALU result valid this cycle.
REQ-011 SHALL have port alu_result  input  8  two's-complement result.
REQ-012 SHALL have ports n1, n2  output  4 each, n1_vld, n2_vld  output  1 each  operand digits + shown flags.
REQ-013 SHALL have port op_code  output  2  00 none, 01 plus, 10 minus.
REQ-014 SHALL have ports eq_vld, res_vld, res_neg  output  1 each; res_tens, res_ones  output  4 each (BCD).
REQ-015 SHALL have port err  output  1  timeout or out-of-range result.

Function
REQ-016 SHALL decode digit keys 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 as 0-9; 0x79 '+', 0x7B '-', 0x55 '=', 0x76 Esc.
REQ-017 SHALL on key_valid with 0xF0 set a break flag; the next key_valid byte SHALL be discarded and clear the flag.
REQ-018 SHALL ignore 0xE0 bytes (no state change) and decode the following byte normally.
REQ-019 SHALL ignore every undecoded code and every key not legal in the current state.
REQ-020 SHALL implement states S_N1, S_OP, S_N2, S_EQ, S_REQ, S_SHOW, S_ERR.
REQ-021 S_N1: digit -> load n1, n1_vld=1, go S_OP.
REQ-022 S_OP: '+'/'-' -> load op_code, go S_N2; digit -> overwrite n1, stay.
REQ-023 S_N2: digit -> load n2, n2_vld=1, go S_EQ.
REQ-024 S_EQ: '=' -> eq_vld=1, go S_REQ; digit -> overwrite n2, stay.
REQ-025 S_REQ: alu_req=1 from the cycle after '=' accepted until alu_ack sampled high; alu_a=n1, alu_b=n2, alu_op=op_code[1], stable throughout.
REQ-026 On alu_ack in S_REQ: capture alu_result; alu_req=0, res_vld=1, go S_SHOW next cycle.
REQ-027 Result SHALL be range-checked to -9..+18; res_neg=sign, res_tens=|r|/10, res_ones=|r|%10; out of range -> S_ERR, err=1, res_vld=0.
REQ-028 Timeout counter SHALL clear on S_REQ entry, increment each S_REQ cycle; on reaching ACK_TIMEOUT without ack -> S_ERR, err=1, alu_req=0.
REQ-029 S_SHOW: digit -> clear n2, op, eq, result flags, load n1, go S_OP; other keys ignored.
REQ-030 S_ERR: only Esc exits; alu_ack ignored.
REQ-031 Esc in any state SHALL clear all outputs to reset values and go S_N1 next cycle, aborting alu_req.
REQ-032 Esc and alu_ack in same S_REQ cycle: Esc wins, ack discarded.
REQ-033 alu_ack outside S_REQ SHALL be ignored.
REQ-034 key_valid during S_REQ (non-Esc) SHALL be ignored; break-flag tracking continues in all states.

Reset
REQ-035 While reset=0 at a clk edge: state S_N1, break flag 0, counter 0, every output 0.
REQ-036 Reset asserted mid-handshake SHALL drop alu_req the cycle after the edge; no ack pending afterwards.

Verification
REQ-037 Bytes 0x16,0x79,0x16,0x55; ack 3 cycles after req with 0x02 -> n1=1, op=01, n2=1, req held 3 cycles, res_tens=0, res_ones=2, res_neg=0.
REQ-038 Bytes 0x2E,0xF0,0x2E,0x7B,0x3E,0x55; ack 0xFD -> n1=5 (break byte discarded), op=10, n2=8, res_neg=1, res_ones=3.
REQ-039 Sequence 9+9=; ack 0x12 -> res_tens=1, res_ones=8; then digit 0x26 -> n1=3, n2_vld=0, res_vld=0, state S_OP.
REQ-040 ACK_TIMEOUT=4, no ack -> alu_req high 4 cycles then 0, err=1; ack afterwards ignored; 0x76 -> all outputs 0.
REQ-041 Esc and alu_ack same cycle -> S_N1, res_vld stays 0; reset=0 during S_REQ -> alu_req=0 next cycle.
REQ-042 Out-of-order bytes 0x79, 0x55 in S_N1 -> no output change.
